// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-stage constants and the {instr,pc} queue entry layout.
package instr_fetch_queue_pkg;

    localparam int unsigned   INSTR_W  = 32;
    localparam logic [31:0]   RESET_PC = 32'h0000_0000;
    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam int unsigned   ENTRY_W  = 64;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Entry storage for the fetch queue: circular buffer with push, pop and flush.
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  entry_t        wdata_i,
    output entry_t        rdata_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Flush wins over any same-cycle push or pop.
    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) count_d = count_q + 1'b1;
            if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads instr_memory combinationally and queues {instr,pc}
// for decode; redirects flush the queue, illegal fetch addresses raise a sticky fault.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = instr_fetch_queue_pkg::RESET_PC,
    parameter int unsigned IMEM_BYTES = 100,
    parameter int unsigned DEPTH      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic               fault,
    output logic [31:0]        fault_pc
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0]   pc_q, pc_d;
    logic          fault_q, fault_d;
    logic [31:0]   fault_pc_q, fault_pc_d;
    logic          legal, push, pop, empty;
    logic [CW-1:0] count;
    entry_t        head, wentry;

    assign pop    = out_valid & out_ready;
    assign legal  = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
    assign push   = ~redirect_valid & ~fault_q & legal & ((count < CW'(DEPTH)) | pop);
    assign wentry = '{instr: imem_instr, pc: pc_q};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wentry),
        .rdata_o (head),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            fault_d = 1'b0;
        end else if (!fault_q && !legal) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = ~empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a behavioural 100-byte instruction memory.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_queue #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (100),
        .DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    // Word 0/1 are the program prologue; others are "addi x1,x0,idx".
    function automatic logic [31:0] word_at(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (addr > 32'd96 || addr[1:0] != 2'b00) return 32'hDEAD_BEEF;
        if (idx == 32'd0) return 32'h0050_0093;
        if (idx == 32'd1) return 32'h0010_0113;
        return 32'h0000_0093 | (idx << 20);
    endfunction

    assign imem_instr = word_at(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_between_edges();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        #12;
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_pc",       out_pc,         32'h0);
        check("rst_instr",    out_instr,      32'h0);
        check("rst_fault",    32'(fault),     32'd0);
        check("rst_fault_pc", fault_pc,       32'h0);
        check("rst_addr",     imem_addr,      32'h0);
        rst_n = 1'b1;

        // 1: back-to-back delivery from RESET_PC
        tick();
        check("t1_valid0", 32'(out_valid), 32'd1);
        check("t1_pc0",    out_pc,    32'h0);
        check("t1_instr0", out_instr, 32'h0050_0093);
        tick();
        check("t1_pc4",    out_pc,    32'h4);
        check("t1_instr4", out_instr, 32'h0010_0113);
        tick();
        check("t1_pc8",    out_pc,    32'h8);
        check("t1_instr8", out_instr, 32'h0020_0093);

        // 2: back-pressure fills the queue and holds the pc
        out_ready = 1'b0;
        reset_between_edges();
        for (int i = 0; i < 5; i++) tick();
        check("t2_full_pc",   out_pc,    32'h0);
        check("t2_full_addr", imem_addr, 32'h8);
        check("t2_full_cnt",  32'(dut.count), 32'd2);
        out_ready = 1'b1;
        tick();
        check("t2_pc4", out_pc, 32'h4);
        check("t2_cnt", 32'(dut.count), 32'd2);
        tick();
        check("t2_pc8",    out_pc,    32'h8);
        check("t2_instr8", out_instr, 32'h0020_0093);

        // 3: redirect while full and popping
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        redirect_valid = 1'b0;
        check("t3_bubble", 32'(out_valid), 32'd0);
        check("t3_addr",   imem_addr, 32'h20);
        tick();
        check("t3_valid",  32'(out_valid), 32'd1);
        check("t3_pc20",   out_pc,    32'h20);
        check("t3_instr",  out_instr, 32'h0080_0093);
        tick();
        check("t3_pc24",   out_pc,    32'h24);

        // 4: run to the end of memory
        guard = 0;
        while (out_pc != 32'h60 && guard < 40) begin
            tick();
            guard++;
        end
        check("t4_reach60",  out_pc,    32'h60);
        check("t4_instr60",  out_instr, 32'h0180_0093);
        check("t4_addr64",   imem_addr, 32'h64);
        check("t4_nofault",  32'(fault), 32'd0);
        tick();
        check("t4_fault",    32'(fault), 32'd1);
        check("t4_fault_pc", fault_pc,  32'h64);
        check("t4_drained",  32'(out_valid), 32'd0);
        check("t4_pc_hold",  imem_addr, 32'h64);

        // 5: misaligned redirect faults, aligned redirect recovers
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        tick();
        redirect_valid = 1'b0;
        check("t5_clear",    32'(fault), 32'd0);
        tick();
        check("t5_fault",    32'(fault), 32'd1);
        check("t5_fault_pc", fault_pc,  32'h22);
        check("t5_novalid",  32'(out_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        check("t5_recover",  32'(fault), 32'd0);
        tick();
        check("t5_valid",    32'(out_valid), 32'd1);
        check("t5_pc10",     out_pc,    32'h10);
        check("t5_instr10",  out_instr, 32'h0040_0093);

        // 6: asynchronous reset mid-stream
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid",    32'(out_valid), 32'd0);
        check("t6_pc",       out_pc,    32'h0);
        check("t6_instr",    out_instr, 32'h0);
        check("t6_addr",     imem_addr, 32'h0);
        check("t6_fault",    32'(fault), 32'd0);
        check("t6_fault_pc", fault_pc,  32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_restart_v",  32'(out_valid), 32'd1);
        check("t6_restart_pc", out_pc,    32'h0);
        tick();
        check("t6_next_pc",    out_pc,    32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
